// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Select/capture bundle between the scan controller and its driver/observer.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              cont;
  logic              y;
  logic              s1;
  logic              s0;
  logic [NUM_CH-1:0] frame;
  logic              frame_valid;
  logic              busy;

  modport master (
    output start, cont, y,
    input  s1, s0, frame, frame_valid, busy
  );

  modport slave (
    input  start, cont, y,
    output s1, s0, frame, frame_valid, busy
  );

endinterface

// File: rtl/mux4to1.sv
// Combinational 4:1 multiplexer whose select lines are driven by the scan controller.
module mux4to1 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s1,
  input  logic s0,
  output logic y
);

  assign y = s1 ? (s0 ? d : c) : (s0 ? b : a);

endmodule

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Per-channel dwell counter; tick marks the last cycle of a dwell period.
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CW    = $clog2(DWELL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, holds each for DWELL cycles,
// captures y at the end of each dwell and publishes the 4-bit frame.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW    = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] shreg_q, shreg_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic              fv_q, fv_d;
  logic              tick;

  // Counter is held clear while idle so a new scan always starts a full dwell.
  dwell_counter #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .en   (state_q == SCAN),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    fv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          sel_d   = '0;
        end
      end
      SCAN: begin
        if (tick) begin
          shreg_d[sel_q] = bus.y;
          if (sel_q != LAST_CH) begin
            sel_d = sel_q + SEL_W'(1);
          end else begin
            // Last channel goes straight into the frame, bypassing shreg.
            frame_d = {bus.y, shreg_q[NUM_CH-2:0]};
            fv_d    = 1'b1;
            sel_d   = '0;
            if (!bus.cont) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      shreg_q <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.s1          = sel_q[1];
  assign bus.s0          = sel_q[0];
  assign bus.frame       = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = (state_q == SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Integration bench: two scan controllers (DWELL=4 and DWELL=1) each closing
// the loop through a mux4to1, checked against a cycle-count reference model.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       start_v [2];
  logic       cont_v  [2];

  always #5 clk = ~clk;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if1 ();

  mux_scan_ctrl #(.DWELL(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_scan_ctrl #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  mux4to1 mux0 (.a(data[0]), .b(data[1]), .c(data[2]), .d(data[3]),
                .s1(if0.s1), .s0(if0.s0), .y(if0.y));
  mux4to1 mux1 (.a(data[0]), .b(data[1]), .c(data[2]), .d(data[3]),
                .s1(if1.s1), .s0(if1.s0), .y(if1.y));

  assign if0.start = start_v[0];
  assign if0.cont  = cont_v[0];
  assign if1.start = start_v[1];
  assign if1.cont  = cont_v[1];

  logic       busy_w  [2];
  logic       fv_w    [2];
  logic [1:0] sel_w   [2];
  logic [3:0] frame_w [2];

  assign busy_w[0]  = if0.busy;
  assign fv_w[0]    = if0.frame_valid;
  assign sel_w[0]   = {if0.s1, if0.s0};
  assign frame_w[0] = if0.frame;
  assign busy_w[1]  = if1.busy;
  assign fv_w[1]    = if1.frame_valid;
  assign sel_w[1]   = {if1.s1, if1.s0};
  assign frame_w[1] = if1.frame;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: time since scan start decides the channel; the bit for
  // channel i is taken from the data inputs at the end of its dwell.
  int         dw [2] = '{4, 1};
  bit         m_busy  [2];
  int         m_t     [2];
  logic [3:0] m_bits  [2];
  logic [3:0] m_frame [2];
  bit         m_fv    [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k]  <= 1'b0;
        m_t[k]     <= 0;
        m_bits[k]  <= '0;
        m_frame[k] <= '0;
        m_fv[k]    <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin : step
        int         ch;
        logic [3:0] bits;
        ch   = m_t[k] / dw[k];
        bits = m_bits[k];
        m_fv[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (start_v[k]) begin
            m_busy[k] <= 1'b1;
            m_t[k]    <= 0;
          end
        end else if ((m_t[k] + 1) % dw[k] != 0) begin
          m_t[k] <= m_t[k] + 1;
        end else begin
          bits[ch] = data[ch];
          m_bits[k] <= bits;
          if (ch == 3) begin
            m_frame[k] <= bits;
            m_fv[k]    <= 1'b1;
            m_t[k]     <= 0;
            if (!cont_v[k]) m_busy[k] <= 1'b0;
          end else begin
            m_t[k] <= m_t[k] + 1;
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int k = 0; k < 2; k++) begin
        check(k == 0 ? "d4_busy"  : "d1_busy",  8'(busy_w[k]),  8'(m_busy[k]));
        check(k == 0 ? "d4_sel"   : "d1_sel",   8'(sel_w[k]),
              8'(m_busy[k] ? m_t[k] / dw[k] : 0));
        check(k == 0 ? "d4_frame" : "d1_frame", 8'(frame_w[k]), 8'(m_frame[k]));
        check(k == 0 ? "d4_fv"    : "d1_fv",    8'(fv_w[k]),    8'(m_fv[k]));
      end
    end
  end

  task automatic wait_fv(input int k, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fv_w[k] && n < limit);
    check("fv_timeout", 8'(fv_w[k]), 8'd1);
  endtask

  task automatic scan_and_wait(input int k, input int limit, output int n);
    start_v[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start_v[k] = 1'b0;
    end while (!fv_w[k] && n < limit);
    check("fv_timeout", 8'(fv_w[k]), 8'd1);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_busy",  8'(busy_w[k]),  8'd0);
    check("rst_sel",   8'(sel_w[k]),   8'd0);
    check("rst_frame", 8'(frame_w[k]), 8'd0);
    check("rst_fv",    8'(fv_w[k]),    8'd0);
  endtask

  initial begin
    int n;
    int cnt;
    rst     = 1'b1;
    data    = '0;
    start_v = '{1'b0, 1'b0};
    cont_v  = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    chk_en = 1'b1;

    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(fv_w[0]) + int'(fv_w[1]);
    end
    check("idle_fv", 8'(cnt), 8'd0);

    // Single shot, DWELL=4, only channel a high.
    data = 4'b0001;
    scan_and_wait(0, 40, n);
    check("ss_lat",   8'(n), 8'd17);
    check("ss_frame", 8'(frame_w[0]), 8'h1);
    check("ss_busy",  8'(busy_w[0]),  8'd0);

    // Continuous mode, DWELL=4.
    data      = 4'b0110;
    cont_v[0] = 1'b1;
    scan_and_wait(0, 40, n);
    check("cont_frame1", 8'(frame_w[0]), 8'h6);
    wait_fv(0, 40, n);
    check("cont_period", 8'(n), 8'd16);
    check("cont_frame2", 8'(frame_w[0]), 8'h6);
    repeat (3) @(negedge clk);
    data = 4'b1110;
    wait_fv(0, 40, n);
    check("cont_d_frame", 8'(frame_w[0]), 8'hE);
    repeat (5) @(negedge clk);
    cont_v[0] = 1'b0;
    wait_fv(0, 40, n);
    check("drop_frame", 8'(frame_w[0]), 8'hE);
    check("drop_busy",  8'(busy_w[0]),  8'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(fv_w[0]);
    end
    check("drop_no_more_fv", 8'(cnt), 8'd0);

    // DWELL=1: select walks every cycle; a start mid-scan is ignored.
    data       = 4'b1111;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    check("d1_sel0", 8'(sel_w[1]), 8'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("d1_seq", 8'(sel_w[1]), 8'(i));
      if (i == 1) start_v[1] = 1'b1;
      if (i == 3) start_v[1] = 1'b0;
    end
    @(negedge clk);
    check("d1_fv",    8'(fv_w[1]),    8'd1);
    check("d1_frame", 8'(frame_w[1]), 8'hF);
    check("d1_busy",  8'(busy_w[1]),  8'd0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(fv_w[1]);
    end
    check("d1_single_fv", 8'(cnt), 8'd0);

    // Reset mid-scan discards the partial frame.
    data       = 4'b1010;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(fv_w[0]);
    end
    check("rst_no_fv", 8'(cnt), 8'd0);
    scan_and_wait(0, 40, n);
    check("post_rst_lat",   8'(n), 8'd17);
    check("post_rst_frame", 8'(frame_w[0]), 8'hA);

    // Randomized traffic on both controllers, checked cycle by cycle.
    repeat (600) begin
      @(negedge clk);
      data = 4'($urandom);
      for (int k = 0; k < 2; k++) begin
        start_v[k] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 31) == 0) cont_v[k] = ~cont_v[k];
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Select-line sequencer and capture stage that drives the `s1`/`s0` inputs of the 4:1 multiplexer and samples its `y` output. It steps through all four channels, holds each for a programmable dwell, and registers `y` into a 4-bit frame. It then presents the frame with a one-cycle valid pulse. It is the control and capture stage wrapped around `mux4to1`: upstream on the select lines, downstream on `y`.

## Interface
- `DWELL`, default 4: clock cycles each channel is held before `y` is sampled. Legal range is 1..255.
- `CW`, default `$clog2(DWELL+1)`: dwell counter width. Derived; never overridden.
- `clk  input  1`: single clock, all state on the rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `start  input  1`: request one scan. Sampled only in IDLE.
- `cont  input  1`: continuous mode. Sampled at each frame completion.
- `y  input  1`: mux output. Combinational from `s1`/`s0`.
- `s1  output  1`: select MSB, registered.
- `s0  output  1`: select LSB, registered.
- `frame  output  4`: captured frame. `frame[i]` = `y` while `{s1,s0}==i`.
- `frame_valid  output  1`: one-cycle pulse when `frame` updates.
- `busy  output  1`: high while scanning.

## Operation
- States:
  - IDLE: `{s1,s0}=00`, `busy=0`.
  - SCAN: `busy=1`, internal `sel[1:0]` drives `{s1,s0}`, `cnt[CW-1:0]` counts dwell.
- IDLE -> SCAN when `start=1` at an edge:
  - `sel<=0`, `cnt<=0`.
- In SCAN, each edge:
  - If `cnt != DWELL-1`: `cnt<=cnt+1`.
  - Otherwise: `shreg[sel]<=y` and `cnt<=0`.
    - If `sel!=3`: `sel<=sel+1`.
    - If `sel==3`: frame completes.
- Frame complete, all at the same edge:
  - `frame<={y, shreg[2:0]}`.
  - `frame_valid<=1` for exactly one cycle.
  - If `cont=1`: `sel<=0`, remain in SCAN.
  - Otherwise: go to IDLE, `{s1,s0}<=00`.
- `start` while in SCAN is ignored. It is not queued.
- `cont` deasserted mid-frame: the current frame finishes, then the block goes to IDLE.
- `frame` holds its last value until the next completion. It is never cleared except by reset.
- Arithmetic:
  - `sel` wraps 3->0 only at completion.
  - `cnt` never exceeds `DWELL-1`.
  - No overflow paths.

## Timing
- Reset values: `s1=0`, `s0=0`, `frame=4'b0000`, `frame_valid=0`, `busy=0`; state is IDLE, `cnt=0`, `sel=0`, `shreg=0`.
- Reset asserted mid-scan:
  - Immediate asynchronous return to IDLE.
  - The partial frame is discarded and no `frame_valid` is issued.
- Start latency:
  - `start` sampled at edge E0.
  - Select changes to 00 and `busy` rises after E0.
  - Channel i is sampled at edge E0 + (i+1)·DWELL.
- Frame latency: `frame_valid` is high in the cycle after edge E0 + 4·DWELL.
- Continuous mode: `frame_valid` pulses every 4·DWELL cycles, with no gap cycles.
- `DWELL=1`: select changes every cycle; `y` is sampled one full cycle after each select change.
- Single-shot return: `busy` falls in the same cycle `frame_valid` is high. A new `start` in that cycle is accepted.
- `y` must settle within one cycle of a select change. The mux is combinational.

## Structure
- Package `mux_scan_pkg`:
  - state enum `{IDLE, SCAN}`.
  - `NUM_CH = 4`.
  - `SEL_W = 2`.
- Sub-module `dwell_counter`:
  - Parameterized by `DWELL`.
  - Inputs: clear/enable.
  - Output: `tick` when `cnt==DWELL-1`.
- The top-level holds the FSM, `sel`, `shreg` and the output registers.
- The integration bench instantiates `mux4to1` with `y` fed back.

## Test plan
- Reset, then idle:
  - Required after reset: all outputs 0, `busy=0`.
  - Hold `start=0` for 20 cycles: no `frame_valid`.
- `DWELL=4`, `a=1`, `b=c=d=0`, single `start` pulse:
  - `frame_valid` high exactly 17 cycles after the start edge.
  - `frame=4'b0001`.
  - `busy` drops in the same cycle.
- `DWELL=4`, `cont=1`:
  - Inputs `a,b,c,d=0,1,1,0`: `frame=4'b0110` every 16 cycles.
  - Change to `d=1` mid-run: the next complete frame shows `4'b1110`.
  - Drop `cont` mid-frame: that frame completes, then `busy=0`.
- `DWELL=1`, `a=b=c=d=1`:
  - `{s1,s0}` sequence 00,01,10,11.
  - `frame=4'b1111` at cycle 5.
  - A `start` asserted during the scan is ignored (only one `frame_valid`).
- Assert `rst` for 1 cycle at cycle 7 of a `DWELL=4` scan:
  - Outputs return to reset values immediately.
  - No `frame_valid` is issued.
  - A following `start` yields a correct frame 17 cycles later.
